// File: rtl/irq_pkg.sv
// irq_ctrl shared definitions: FSM encoding, register map
// and CAUSE register bit positions.
package irq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } irq_state_t;

  localparam logic [1:0] ADDR_MASK  = 2'd0;
  localparam logic [1:0] ADDR_PEND  = 2'd1;
  localparam logic [1:0] ADDR_CAUSE = 2'd2;

  localparam int CAUSE_VALID_BIT = 31;
  localparam int CAUSE_ID_HI     = 4;
  localparam int CAUSE_ID_LO     = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest or highest set index wins,
// chosen by i_high_first.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  input  logic         i_high_first,
  output logic         o_valid,
  output logic [4:0]   o_id
);

  always_comb begin
    o_valid = |i_req;
    o_id    = '0;
    if (i_high_first) begin
      for (int i = 0; i < N; i++)
        if (i_req[i]) o_id = 5'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (i_req[i]) o_id = 5'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: MASK/PENDING/CAUSE registers, IDLE/REQ/SERVICE FSM.
// Define IRQ_EDGE_DETECT_EN for sticky rising-edge pending bits.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC           = 8,
  parameter int PRIO_HIGH_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  output logic             irq_out,
  input  logic             eret_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             busy
);

  irq_state_t       r_state;
  irq_state_t       w_next;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [4:0]       r_cause_id;
  logic             r_cause_valid;
  logic             r_irq;

  logic             w_wr_mask;
  logic [N_SRC-1:0] w_mask_eff;
  logic [N_SRC-1:0] w_req;
  logic             w_hit;
  logic [4:0]       w_win_id;
  logic             w_latch;
  logic             w_done;
  logic [31:0]      w_mask_x;
  logic [31:0]      w_pend_x;
  logic [31:0]      w_cause_x;
  logic             w_unused;

  assign w_wr_mask  = reg_we && (reg_addr == ADDR_MASK);
  assign w_mask_eff = w_wr_mask ? reg_wdata[N_SRC-1:0] : r_mask;
  assign w_req      = r_pend & w_mask_eff;
  assign w_unused   = ^reg_wdata;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .i_req        (w_req),
    .i_high_first (PRIO_HIGH_FIRST != 0),
    .o_valid      (w_hit),
    .o_id         (w_win_id)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_next  = S_REQ;
          w_latch = 1'b1;
        end
      end
      S_REQ: w_next = S_SERVICE;
      S_SERVICE: begin
        if (eret_in) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // irq_out is a flop mirroring entry into REQ, so it is glitch-free
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (w_next == S_REQ);
  end

  assign irq_out = r_irq;
  assign busy    = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause_valid <= 1'b0;
      r_cause_id    <= '0;
    end else if (w_latch) begin
      r_cause_valid <= 1'b1;
      r_cause_id    <= w_win_id;
    end else if (w_done) begin
      r_cause_valid <= 1'b0;
      r_cause_id    <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_mask <= '0;
    else if (w_wr_mask) r_mask <= reg_wdata[N_SRC-1:0];
  end

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] w_set;
  logic [N_SRC-1:0] w_clr;
  logic             w_wr_pend;

  assign w_wr_pend = reg_we && (reg_addr == ADDR_PEND);
  assign w_set     = src_irq & ~r_prev;
  assign w_clr     = (w_wr_pend ? reg_wdata[N_SRC-1:0] : '0)
                   | (w_done ? (N_SRC'(1) << r_cause_id) : '0);

  // history tracks src_irq even in reset so held lines are not edges
  always_ff @(posedge clk) begin
    r_prev <= src_irq;
    if (rst) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_clr) | w_set;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) r_pend <= '0;
    else     r_pend <= src_irq;
  end
`endif

  always_comb begin
    w_mask_x = '0;
    w_mask_x[N_SRC-1:0] = r_mask;
    w_pend_x = '0;
    w_pend_x[N_SRC-1:0] = r_pend;
    w_cause_x = '0;
    w_cause_x[CAUSE_VALID_BIT] = r_cause_valid;
    w_cause_x[CAUSE_ID_HI:CAUSE_ID_LO] = r_cause_id;
    unique case (reg_addr)
      ADDR_MASK:  reg_rdata = w_mask_x;
      ADDR_PEND:  reg_rdata = w_pend_x;
      ADDR_CAUSE: reg_rdata = w_cause_x;
      default:    reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (N_SRC=8, lowest index wins).
// Expectations cover both level and edge-detect pending builds.
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  src_irq;
  logic        irq_out;
  logic        eret_in;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        busy;

  int checks;
  int errors;

  irq_ctrl #(.N_SRC(8), .PRIO_HIGH_FIRST(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_irq   (src_irq),
    .irq_out   (irq_out),
    .eret_in   (eret_in),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic exp_irq,
                        input logic exp_busy);
    chk({tag, ".irq"}, 32'(irq_out), 32'(exp_irq));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a;
    #1;
    d = reg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    step(1);
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  task automatic eret();
    eret_in = 1'b1;
    step(1);
    eret_in = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    src_irq   = 8'hFF;
    eret_in   = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = 2'd0;
    reg_wdata = '0;

    // reset defaults with all lines high and MASK=0
    step(2);
    rst = 1'b0;
    step(1);
    chk_st("rst0", 1'b0, 1'b0);
    step(2);
    chk_st("rst1", 1'b0, 1'b0);
    rd(2'd2, d); chk("rst.cause", d, 32'h0);
    rd(2'd0, d); chk("rst.mask", d, 32'h0);
`ifdef IRQ_EDGE_DETECT_EN
    rd(2'd1, d); chk("rst.pend", d, 32'h0);
`else
    rd(2'd1, d); chk("rst.pend", d, 32'hFF);
`endif
    rd(2'd3, d); chk("addr3", d, 32'h0);
    src_irq = 8'h00;
    step(2);

    // basic request on source 3
    wr(2'd0, 32'h0C);
    rd(2'd0, d); chk("mask", d, 32'h0C);
    src_irq = 8'h08;
    step(1);
    chk_st("b.c1", 1'b0, 1'b0);
    step(1);
    chk_st("b.req", 1'b1, 1'b1);
    rd(2'd2, d); chk("b.cause", d, 32'h8000_0003);
    step(1);
    chk_st("b.svc", 1'b0, 1'b1);
    src_irq = 8'h00;
    step(2);
    chk_st("b.wait", 1'b0, 1'b1);
    eret();
    chk_st("b.eret", 1'b0, 1'b0);
    rd(2'd1, d); chk("b.pend", d, 32'h0);
    rd(2'd2, d); chk("b.cause0", d, 32'h0);
    step(1);
    chk_st("b.idle", 1'b0, 1'b0);

    // priority: 2 and 5 together, 2 first
    wr(2'd0, 32'hFF);
    src_irq = 8'h24;
    step(2);
    chk_st("p.req2", 1'b1, 1'b1);
    rd(2'd2, d); chk("p.cause2", d, 32'h8000_0002);
    step(1);
    src_irq = 8'h20;
    eret();
    chk_st("p.eret", 1'b0, 1'b0);
    step(1);
    chk_st("p.req5", 1'b1, 1'b1);
    rd(2'd2, d); chk("p.cause5", d, 32'h8000_0005);
    step(1);
    src_irq = 8'h00;
    eret();
    step(2);
    chk_st("p.idle", 1'b0, 1'b0);

    // no preemption: source 1 arrives while servicing 4
    src_irq = 8'h10;
    step(2);
    chk_st("n.req4", 1'b1, 1'b1);
    rd(2'd2, d); chk("n.cause4", d, 32'h8000_0004);
    step(1);
    src_irq = 8'h12;
    step(1); chk_st("n.h1", 1'b0, 1'b1);
    step(1); chk_st("n.h2", 1'b0, 1'b1);
    step(1); chk_st("n.h3", 1'b0, 1'b1);
    rd(2'd2, d); chk("n.cause", d, 32'h8000_0004);
    src_irq = 8'h02;
    eret();
    chk_st("n.eret", 1'b0, 1'b0);
    step(1);
    chk_st("n.req1", 1'b1, 1'b1);
    rd(2'd2, d); chk("n.cause1", d, 32'h8000_0001);
    step(1);
    src_irq = 8'h00;
    eret();
    step(2);
    chk_st("n.idle", 1'b0, 1'b0);

    // set wins over simultaneous W1C (FSM kept quiet with MASK=0)
    wr(2'd0, 32'h0);
    src_irq = 8'h40;
    wr(2'd1, 32'h40);
    rd(2'd1, d); chk("sw.pend", d, 32'h40);
    chk_st("sw.quiet", 1'b0, 1'b0);
    wr(2'd1, 32'h40);
`ifdef IRQ_EDGE_DETECT_EN
    rd(2'd1, d); chk("w1c.pend", d, 32'h0);
`else
    rd(2'd1, d); chk("w1c.pend", d, 32'h40);
`endif
    src_irq = 8'h00;
    step(2);

    // reset in REQ: no pulse afterwards
    wr(2'd0, 32'hFF);
    src_irq = 8'h01;
    step(2);
    chk_st("r.req", 1'b1, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_st("r.abort", 1'b0, 1'b0);
    src_irq = 8'h00;
    step(2);

    // reset in SERVICE, stale ERET ignored
    wr(2'd0, 32'hFF);
    src_irq = 8'h01;
    step(3);
    chk_st("rs.svc", 1'b0, 1'b1);
    src_irq = 8'h00;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_st("rs.rst", 1'b0, 1'b0);
    rd(2'd1, d); chk("rs.pend", d, 32'h0);
    rd(2'd2, d); chk("rs.cause", d, 32'h0);
    rd(2'd0, d); chk("rs.mask", d, 32'h0);
    eret();
    chk_st("rs.eret", 1'b0, 1'b0);
    step(1);
    chk_st("rs.after", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 8, meaning number of interrupt source lines (1..32).
REQ-002 SHALL have parameter PRIO_HIGH_FIRST, default 0, meaning 0 = lowest source index wins, 1 = highest index wins.
REQ-003 SHALL have port clk, input, 1 bit, meaning main clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have port src_irq, input, N_SRC bits, meaning raw peripheral interrupt lines.
REQ-006 SHALL have port irq_out, output, 1 bit, meaning interrupt request pulse to the CP0 ir_in input.
REQ-007 SHALL have port eret_in, input, 1 bit, meaning one-cycle strobe that the CPU executed ERET (end of service).
REQ-008 SHALL have ports reg_we (input, 1 bit), reg_addr (input, 2 bits), reg_wdata (input, 32 bits) and reg_rdata (output, 32 bits), meaning the CPU register access port.
REQ-009 SHALL have port busy, output, 1 bit, meaning an interrupt is being requested or serviced.

Function
REQ-010 SHALL keep a register map: addr 0 MASK (R/W, bit i = 1 enables source i); addr 1 PENDING (R, W1C); addr 2 CAUSE (R, {valid at bit 31, source id at bits 4:0}); addr 3 reads 0 and ignores writes.
REQ-011 SHALL provide reg_rdata combinationally from reg_addr, with bits at and above N_SRC reading 0.
REQ-012 SHALL implement FSM states IDLE, REQ and SERVICE.
REQ-013 SHALL move from IDLE to REQ when (PENDING & MASK) != 0, latching the winning id into CAUSE and setting CAUSE.valid.
REQ-014 SHALL assert irq_out for exactly the one cycle spent in REQ, then move unconditionally to SERVICE.
REQ-015 SHALL stay in SERVICE until eret_in = 1; on that edge it SHALL clear the PENDING bit of CAUSE.id, clear CAUSE.valid and return to IDLE.
REQ-016 SHALL ignore eret_in in IDLE and REQ.
REQ-017 SHALL hold busy = 1 in REQ and SERVICE, and 0 in IDLE.
REQ-018 SHALL select the winner by fixed priority per PRIO_HIGH_FIRST; ties are impossible.
REQ-019 SHALL let new pending sources arriving during SERVICE be accumulated, not preempt; the earliest IRQ after ERET is raised on the cycle following the return to IDLE (IDLE->REQ takes one cycle, irq_out is registered).
REQ-020 SHALL, when a source sets and is cleared (W1C or ERET) in the same cycle, leave the bit set (set wins).
REQ-021 SHALL apply a MASK write in the cycle it occurs; a write that masks the latched CAUSE source SHALL NOT abort SERVICE.
REQ-022 SHALL apply a W1C write to the bit being serviced, and SERVICE SHALL still wait for eret_in.

Reset
REQ-023 SHALL on rst set MASK = 0, PENDING = 0, CAUSE = 0, state = IDLE, irq_out = 0 and busy = 0.
REQ-024 SHALL let rst asserted in REQ or SERVICE abort immediately, with no irq_out pulse on the following cycle.
REQ-025 SHALL resample edge-detect history to the current src_irq during rst, so a line high at reset release is not counted as an edge.

Configuration
REQ-026 SHALL, with macro IRQ_EDGE_DETECT_EN defined, set PENDING[i] sticky on a rising edge of src_irq[i], with clearing only by W1C or ERET.
REQ-027 SHALL, without IRQ_EDGE_DETECT_EN, treat PENDING as level (PENDING = src_irq, W1C ignored, ERET clears nothing); a line still high after ERET re-raises the request.

Structure
REQ-028 SHALL place the FSM state encoding, the register address constants (ADDR_MASK/PEND/CAUSE) and the CAUSE bit positions in shared package irq_pkg.
REQ-029 SHALL implement the priority selection in sub-module irq_prio_enc (inputs: request vector and direction; outputs: valid and id).

Verification
REQ-030 SHALL verify reset defaults: after rst, MASK=0 and src_irq=8'hFF give no irq_out, and reg_rdata at addr 2 reads 0.
REQ-031 SHALL verify a basic request: MASK=8'h0C with src_irq[3] rising gives a one-cycle irq_out, CAUSE=32'h8000_0003, busy=1; after eret_in, PENDING[3]=0, busy=0 and CAUSE=0.
REQ-032 SHALL verify priority: src 2 and 5 rising together with MASK=8'hFF and PRIO_HIGH_FIRST=0 service id 2 first, then after eret_in a second irq_out with id 5.
REQ-033 SHALL verify no preemption: src 1 rising during SERVICE of id 4 gives no irq_out until after eret_in, then id 1 is raised one cycle later.
REQ-034 SHALL verify set wins: src 6 rising on the same cycle as a W1C of 8'h40 leaves PENDING[6]=1.
REQ-035 SHALL verify reset mid-operation: rst asserted in SERVICE returns busy=0 and PENDING=0 next cycle, and the stale eret_in afterwards has no effect.
